sha256_round_sequencer: RTL

SHA256_ROUND_SEQUENCER -- requirements
Module: sha256_round_sequencer

---
 rtl/sha256_round_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/sha256_round_sequencer.sv
// Feeds an external SHA-256 round core one 512-bit block: buffers W0..W15, expands the schedule, adds the feed-forward.
// Optional define SHA_SEQ_CHAIN_EN adds a chain input so a block can continue from the previous digest.
module sha256_round_sequencer (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] h_init,
`ifdef SHA_SEQ_CHAIN_EN
  input  logic         chain,
`endif
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [31:0]  msg_word,
  output logic         core_mode,
  output logic [5:0]   core_round_n,
  output logic [31:0]  core_wi,
  output logic [255:0] core_init,
  input  logic [255:0] core_state,
  output logic         busy,
  output logic         done,
  output logic [255:0] digest
);

  typedef enum logic [2:0] {IDLE, FILL, LOAD, ROUND, DONE} state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [5:0]    round_q;
  logic [31:0]   win_q [16];
  logic [255:0]  hinit_q;
  logic [255:0]  digest_q;
  logic [31:0]   wi_q;
  logic          mode_q;
  logic          ready_q;
  logic          busy_q;
  logic          done_q;
  logic [31:0]   w16_d;
  logic [255:0]  hstart_d;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // win_q[0] is always the current W_t; the next word enters at win_q[15].
  always_comb begin
    w16_d = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
  end

  always_comb begin
    hstart_d = h_init;
`ifdef SHA_SEQ_CHAIN_EN
    if (chain) hstart_d = digest_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      round_q  <= '0;
      hinit_q  <= '0;
      digest_q <= '0;
      wi_q     <= '0;
      mode_q   <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) win_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            hinit_q <= hstart_d;
            cnt_q   <= '0;
            state_q <= FILL;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        FILL: begin
          if (msg_valid) begin
            for (int unsigned i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
            win_q[15] <= msg_word;
            cnt_q     <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              state_q <= LOAD;
              ready_q <= 1'b0;
              mode_q  <= 1'b1;
              // after this shift the old win_q[1] lands at W0
              wi_q    <= win_q[1];
            end
          end
        end
        LOAD: begin
          state_q <= ROUND;
          mode_q  <= 1'b0;
          round_q <= '0;
          wi_q    <= win_q[0];
        end
        ROUND: begin
          for (int unsigned i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
          win_q[15] <= w16_d;
          if (round_q == 6'd63) begin
            state_q <= DONE;
            round_q <= '0;
            wi_q    <= '0;
            done_q  <= 1'b1;
            for (int unsigned i = 0; i < 8; i++)
              digest_q[i*32 +: 32] <= hinit_q[i*32 +: 32] + core_state[i*32 +: 32];
          end else begin
            round_q <= round_q + 6'd1;
            wi_q    <= win_q[1];
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign msg_ready    = ready_q;
  assign core_mode    = mode_q;
  assign core_round_n = round_q;
  assign core_wi      = wi_q;
  assign core_init    = hinit_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign digest       = digest_q;

endmodule
